// File: rtl/load_store_unit.sv
// Sized, handshaked load/store unit between the execute stage and a data-memory bus.
// Builds byte strobes and replicated store data, aligns/extends load data, stalls the core.
module load_store_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        misaligned,
  output logic        fault,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  // state  | meaning
  // S_IDLE | waiting for a memory op; issues legal aligned ops
  // S_REQ  | bus_req_valid high until the bus accepts
  // S_WAIT | waiting for response, timeout counter running
  // S_DONE | one un-stalled cycle so the core advances
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [2:0]       lat_funct3;
  logic [1:0]       lat_lane;

  logic        mem_op;
  logic        legal;
  logic        req;
  logic [3:0]  strb_next;
  logic [31:0] wdata_next;
  logic [31:0] rd_byte_sh;
  logic [31:0] rd_half_sh;
  logic [31:0] rd_ext;

  assign mem_op = mem_read | mem_write;

  always_comb begin
    legal = 1'b0;
    if (mem_write)
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    else
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
              (funct3 == 3'b100) || (funct3 == 3'b101);
  end

  // Illegal encodings fault instead of being reported as misaligned.
  assign misaligned = mem_op & legal &
                      (((funct3[1:0] == 2'b01) & addr[0]) |
                       ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00)));

  assign req   = mem_op & legal & ~misaligned;
  assign stall = ((state == S_IDLE) & req) | (state == S_REQ) | (state == S_WAIT);

  always_comb begin
    strb_next  = 4'b1111;
    wdata_next = store_data;
    case (funct3[1:0])
      2'b00: begin
        strb_next  = 4'b0001 << addr[1:0];
        wdata_next = {4{store_data[7:0]}};
      end
      2'b01: begin
        strb_next  = 4'b0011 << addr[1:0];
        wdata_next = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign rd_byte_sh = bus_rdata >> {lat_lane, 3'b000};
  assign rd_half_sh = bus_rdata >> {lat_lane[1], 4'b0000};

  always_comb begin
    rd_ext = bus_rdata;
    case (lat_funct3)
      3'b000:  rd_ext = {{24{rd_byte_sh[7]}}, rd_byte_sh[7:0]};
      3'b001:  rd_ext = {{16{rd_half_sh[15]}}, rd_half_sh[15:0]};
      3'b100:  rd_ext = {24'd0, rd_byte_sh[7:0]};
      3'b101:  rd_ext = {16'd0, rd_half_sh[15:0]};
      default: rd_ext = bus_rdata;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state         <= S_IDLE;
      count         <= '0;
      load_data     <= '0;
      fault         <= 1'b0;
      bus_req_valid <= 1'b0;
      bus_addr      <= '0;
      bus_we        <= 1'b0;
      bus_wstrb     <= '0;
      bus_wdata     <= '0;
      lat_funct3    <= '0;
      lat_lane      <= '0;
    end else begin
      fault <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            bus_addr      <= {addr[31:2], 2'b00};
            bus_we        <= mem_write;
            bus_wstrb     <= mem_write ? strb_next : 4'b0000;
            bus_wdata     <= wdata_next;
            lat_funct3    <= funct3;
            lat_lane      <= addr[1:0];
            bus_req_valid <= 1'b1;
            state         <= S_REQ;
          end else if (mem_op & ~legal) begin
            fault <= 1'b1;
          end
        end
        S_REQ: begin
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            count         <= '0;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus_resp_valid) begin
            state <= S_DONE;
            fault <= bus_err;
            if (!bus_we) load_data <= bus_err ? 32'd0 : rd_ext;
          end else if (count == CNT_W'(TIMEOUT - 1)) begin
            state <= S_DONE;
            fault <= 1'b1;
            if (!bus_we) load_data <= 32'd0;
          end else begin
            count <= count + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: transaction-level model plus per-cycle compare process.
module tb_load_store_unit;
  localparam int TIMEOUT = 16;

  logic        CLK = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, load_data;
  logic        stall, misaligned, fault;
  logic        bus_req_valid, bus_req_ready;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_we, bus_resp_valid, bus_err;
  logic [3:0]  bus_wstrb;

  load_store_unit #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .CLK(CLK), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .store_data(store_data), .load_data(load_data),
    .stall(stall), .misaligned(misaligned), .fault(fault),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_addr(bus_addr),
    .bus_we(bus_we), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_resp_valid(bus_resp_valid), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;
  bit cmp_en = 0;

  logic [31:0] exp_load_data, exp_addr, exp_wdata;
  logic [3:0]  exp_strb;
  logic        exp_we;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_strb;
  logic        seen_we;
  int          last_stalls, last_vcycles;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
  endtask

  // ---- behavioural model ----
  function automatic bit m_legal(input bit wr, input logic [2:0] f3);
    if (wr) return f3 <= 3'd2;
    return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic int m_size(input logic [2:0] f3);  // bytes
    return 1 << (f3 % 4);
  endfunction

  function automatic bit m_mis(input bit wr, input bit rd, input logic [2:0] f3, input logic [31:0] a);
    if (!(wr || rd) || !m_legal(wr, f3)) return 0;
    return (a % m_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int lane;
    logic [31:0] v;
    lane = a % 4;
    if (m_size(f3) == 1) begin
      v = (rd >> (8 * lane)) & 32'hFF;
      if (f3 < 4 && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (m_size(f3) == 2) begin
      v = (rd >> (16 * (lane / 2))) & 32'hFFFF;
      if (f3 < 4 && v >= 32768) v = v + 32'hFFFF_0000;
    end else v = rd;
    return v;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    return 4'(((1 << m_size(f3)) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    if (m_size(f3) == 1) return (sd & 32'hFF) * 32'h0101_0101;
    if (m_size(f3) == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  // ---- per-cycle compare ----
  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("misaligned", misaligned, m_mis(mem_write, mem_read, funct3, addr));
      chk("load_data_hold", load_data, exp_load_data);
      if (bus_req_valid) begin
        chk("bus_addr", bus_addr, exp_addr);
        chk("bus_we", bus_we, exp_we);
        chk("bus_wstrb", bus_wstrb, exp_strb);
        if (exp_we) chk("bus_wdata", bus_wdata, exp_wdata);
      end
    end
  end

  task automatic idle_inputs();
    mem_read = 0; mem_write = 0; bus_req_ready = 0; bus_resp_valid = 0; bus_err = 0;
  endtask

  task automatic run_op(input bit wr, input bit rd, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rdata, input bit err,
                        input int ready_wait, input int resp_wait, input bit no_resp, input bit spurious);
    int stalls, vcycles, wcycles, exp_stalls;
    bit hs_done, fin, lgl, mis;
    logic [31:0] ld_exp;
    stalls = 0; vcycles = 0; wcycles = 0; hs_done = 0; fin = 0;
    lgl = m_legal(wr, f3);
    mis = m_mis(wr, rd, f3, a);
    exp_addr  = {a[31:2], 2'b00};
    exp_we    = wr;
    exp_strb  = wr ? m_strb(f3, a) : 4'b0000;
    exp_wdata = m_wdata(f3, sd);
    mem_write = wr; mem_read = rd; funct3 = f3; addr = a; store_data = sd;
    bus_req_ready = 0; bus_resp_valid = 0; bus_rdata = rdata; bus_err = err;
    if (!lgl || mis) begin
      #1;
      chk("noreq_stall", stall, 0);
      chk("noreq_valid", bus_req_valid, 0);
      @(posedge CLK); #1;
      chk("noreq_fault", fault, !lgl);
      chk("noreq_valid2", bus_req_valid, 0);
      idle_inputs();
      @(posedge CLK); #1;
      chk("noreq_fault_clr", fault, 0);
      return;
    end
    exp_stalls = 1 + (ready_wait + 1) + (no_resp ? TIMEOUT : resp_wait + 1);
    ld_exp = (err || no_resp) ? 32'd0 : m_load(f3, a, rdata);
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      bus_req_ready  = bus_req_valid && (vcycles >= ready_wait);
      bus_resp_valid = (hs_done && !no_resp && wcycles >= resp_wait) ||
                       (spurious && bus_req_valid && !bus_req_ready);
      bus_err   = hs_done ? err : 1'b1;
      bus_rdata = hs_done ? rdata : ~rdata;
      #1;
      if (stall) begin
        stalls++;
        if (fault) chk("fault_while_stalled", fault, 0);
      end else begin
        fin = 1;
        chk("done_fault", fault, err || no_resp);
        chk("stall_cycles", stalls, exp_stalls);
        chk("valid_cycles", vcycles, ready_wait + 1);
        if (rd && !wr) exp_load_data = ld_exp;
        chk("done_load_data", load_data, exp_load_data);
      end
      if (bus_req_valid) begin
        if (vcycles == 0) begin
          seen_addr = bus_addr; seen_we = bus_we; seen_strb = bus_wstrb; seen_wdata = bus_wdata;
        end else chk("addr_stable", bus_addr, seen_addr);
        vcycles++;
      end
      if (hs_done) wcycles++;
      if (bus_req_valid && bus_req_ready) hs_done = 1;
      if (!fin) begin @(posedge CLK); #1; end
    end
    if (!fin) chk("op_completion_budget", 0, 1);
    last_stalls = stalls; last_vcycles = vcycles;
    idle_inputs();
    @(posedge CLK); #1;
    chk("after_done_fault", fault, 0);
    chk("after_done_stall", stall, 0);
  endtask

  initial begin
    reset = 1; funct3 = 0; addr = 0; store_data = 0; bus_rdata = 0;
    idle_inputs();
    exp_load_data = 0; exp_addr = 0; exp_we = 0; exp_strb = 0; exp_wdata = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_load_data", load_data, 0);
    chk("rst_fault", fault, 0);
    chk("rst_valid", bus_req_valid, 0);
    chk("rst_we", bus_we, 0);
    chk("rst_wstrb", bus_wstrb, 0);
    chk("rst_stall", stall, 0);
    reset = 0;
    cmp_en = 1;
    @(posedge CLK); #1;

    // LB with sign extension, minimum latency
    run_op(0, 1, 3'b000, 32'h103, 0, 32'h80FF_1234, 0, 0, 0, 0, 0);
    chk("lit_lb_data", load_data, 32'hFFFF_FF80);
    chk("lit_lb_addr", seen_addr, 32'h100);
    chk("lit_lb_stalls", last_stalls, 3);
    chk("lit_lb_strb", seen_strb, 4'b0000);

    // SH to upper half
    run_op(1, 0, 3'b001, 32'h22, 32'h0000_BEEF, 0, 0, 0, 0, 0, 0);
    chk("lit_sh_strb", seen_strb, 4'b1100);
    chk("lit_sh_wdata", seen_wdata, 32'hBEEF_BEEF);
    chk("lit_sh_we", seen_we, 1);
    chk("lit_sh_keeps_ld", load_data, 32'hFFFF_FF80);

    run_op(1, 0, 3'b000, 32'h11, 32'h1234_56A5, 0, 0, 0, 0, 0, 0);
    chk("lit_sb_wdata", seen_wdata, 32'hA5A5_A5A5);
    chk("lit_sb_strb", seen_strb, 4'b0010);
    run_op(1, 1, 3'b010, 32'h40, 32'hCAFE_F00D, 0, 0, 0, 1, 0, 0);   // write wins
    run_op(0, 1, 3'b001, 32'h202, 0, 32'h8001_7FFF, 0, 0, 0, 0, 0);
    chk("lit_lh_data", load_data, 32'hFFFF_8001);
    run_op(0, 1, 3'b101, 32'h202, 0, 32'h8001_7FFF, 0, 0, 0, 0, 0);
    chk("lit_lhu_data", load_data, 32'h0000_8001);
    run_op(0, 1, 3'b100, 32'h301, 0, 32'h00C3_9A00, 0, 0, 0, 0, 0);
    chk("lit_lbu_data", load_data, 32'h0000_009A);
    run_op(0, 1, 3'b000, 32'h300, 0, 32'h0000_007F, 0, 1, 0, 0, 0);
    run_op(0, 1, 3'b010, 32'h404, 0, 32'hDEAD_BEEF, 0, 0, 2, 0, 0);
    chk("lit_lw_data", load_data, 32'hDEAD_BEEF);

    // misaligned and illegal ops
    run_op(0, 1, 3'b010, 32'h41, 0, 32'h1111_1111, 0, 0, 0, 0, 0);
    run_op(1, 0, 3'b001, 32'h23, 32'h5555, 0, 0, 0, 0, 0, 0);
    run_op(0, 1, 3'b011, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    run_op(1, 0, 3'b100, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    chk("illegal_keeps_ld", load_data, 32'hDEAD_BEEF);

    // slow bus with spurious responses while waiting for ready
    run_op(0, 1, 3'b001, 32'h600, 0, 32'h1234_F00F, 0, 4, 2, 0, 1);
    chk("lit_slow_vcycles", last_vcycles, 5);
    chk("lit_slow_stalls", last_stalls, 9);
    chk("lit_slow_data", load_data, 32'hFFFF_F00F);

    // bus error on a load
    run_op(0, 1, 3'b010, 32'h700, 0, 32'h7777_7777, 1, 0, 1, 0, 0);
    chk("lit_err_data", load_data, 32'h0);

    run_op(0, 1, 3'b010, 32'h704, 0, 32'h0BAD_CAFE, 0, 0, 0, 0, 0);
    // no response -> timeout
    run_op(0, 1, 3'b010, 32'h800, 0, 32'h9999_9999, 0, 0, 0, 1, 0);
    chk("lit_timeout_stalls", last_stalls, 2 + TIMEOUT);
    chk("lit_timeout_data", load_data, 32'h0);

    // reset while in WAIT, then a late response
    run_op(0, 1, 3'b010, 32'h900, 0, 32'h0000_0042, 0, 0, 0, 0, 0);
    mem_read = 1; funct3 = 3'b010; addr = 32'hA00;
    exp_addr = 32'hA00; exp_we = 0; exp_strb = 0;
    @(posedge CLK); #1;
    bus_req_ready = 1;
    @(posedge CLK); #1;
    bus_req_ready = 0;
    @(posedge CLK); #1;
    chk("wait_stall", stall, 1);
    reset = 1; mem_read = 0;
    @(posedge CLK); #1;
    reset = 0;
    exp_load_data = 0;
    bus_resp_valid = 1; bus_rdata = 32'h1234_5678; bus_err = 0;
    #1;
    chk("post_rst_stall", stall, 0);
    chk("post_rst_valid", bus_req_valid, 0);
    @(posedge CLK); #1;
    bus_resp_valid = 0;
    chk("late_resp_load_data", load_data, 32'h0);
    chk("late_resp_fault", fault, 0);
    chk("late_resp_stall", stall, 0);
    @(posedge CLK); #1;
    chk("late_resp_fault2", fault, 0);
    repeat (2) @(posedge CLK);
    cmp_en = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
